// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator car.
// floor_t encodes floors 1..3 (0 is never a valid position).
// Command vector layout is {d2, d1, n, u1, u2}.
package elevator_pkg;

    typedef logic [1:0] floor_t;
    localparam floor_t F1 = 2'd1;
    localparam floor_t F2 = 2'd2;
    localparam floor_t F3 = 2'd3;

    typedef logic [1:0] car_state_t;
    localparam car_state_t StIdle = 2'd0;
    localparam car_state_t StMove = 2'd1;
    localparam car_state_t StDoor = 2'd2;

    typedef logic [4:0] cmd_t;
    localparam int unsigned CMD_U2 = 0;
    localparam int unsigned CMD_U1 = 1;
    localparam int unsigned CMD_N  = 2;
    localparam int unsigned CMD_D1 = 3;
    localparam int unsigned CMD_D2 = 4;
    localparam cmd_t        CMD_NOP = 5'b00100;

    // True when cmd is exactly one bit and its target floor lies within 1..3.
    function automatic logic legal_move(floor_t f, cmd_t cmd);
        logic ok;
        ok = 1'b0;
        if ($onehot(cmd)) begin
            if (cmd[CMD_D2])      ok = (f == F3);
            else if (cmd[CMD_D1]) ok = (f == F2) || (f == F3);
            else if (cmd[CMD_N])  ok = 1'b1;
            else if (cmd[CMD_U1]) ok = (f == F1) || (f == F2);
            else                  ok = (f == F1);
        end
        return ok;
    endfunction

endpackage

// File: rtl/elevator_car_if.sv
// Command/status bundle between an elevator controller and the car.
// master: controller side (drives d2..u2, observes status).
// slave : car side (samples commands, drives status and floor indicators).
interface elevator_car_if;
    import elevator_pkg::*;

    logic   d2, d1, n, u1, u2;
    logic   ready, moving, dir_up, door_open, arrive, cmd_err;
    floor_t floor;
    logic   at_f1, at_f2, at_f3;

    modport master (
        output d2, d1, n, u1, u2,
        input  ready, moving, dir_up, door_open, arrive, cmd_err, floor, at_f1, at_f2, at_f3
    );

    modport slave (
        input  d2, d1, n, u1, u2,
        output ready, moving, dir_up, door_open, arrive, cmd_err, floor, at_f1, at_f2, at_f3
    );

endinterface

// File: rtl/elevator_timer.sv
// Loadable down-counter shared by the travel and door phases.
// Ports: clk/rst (sync, active-high), load_i/load_val_i load a value,
// dec_i decrements (saturating at 0), count_o current value, zero_o count==0.
module elevator_timer #(
    parameter int unsigned Width = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic [Width-1:0] count_o,
    output logic             zero_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/elevator_car.sv
// Elevator car plant: executes one-hot move commands with per-floor travel
// time and a door dwell, and reports position as encoded and one-hot floor.
// Ports: clk, rst (sync, active-high), car (elevator_car_if.slave) carrying
// commands d2/d1/n/u1/u2 in and ready/moving/dir_up/door_open/arrive/
// cmd_err/floor/at_f1..at_f3 out.
module elevator_car
    import elevator_pkg::*;
#(
    parameter int unsigned FLOOR_TICKS = 4,
    parameter int unsigned DOOR_TICKS  = 3
) (
    input logic           clk,
    input logic           rst,
    elevator_car_if.slave car
);

    localparam int unsigned MaxTicks  = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int unsigned CntW      = $clog2(MaxTicks + 1);
    localparam logic [CntW-1:0] FloorLoad = CntW'(FLOOR_TICKS - 1);
    localparam logic [CntW-1:0] DoorLoad  = CntW'(DOOR_TICKS - 1);

    car_state_t state_q, state_d;
    floor_t     floor_q, floor_d;
    logic       dir_q, dir_d;
    logic       two_q, two_d;        // a second floor still to travel
    logic       err_q, err_d;

    logic            tmr_load, tmr_dec, tmr_zero;
    logic [CntW-1:0] tmr_load_val, tmr_count;
    cmd_t            cmd;

    assign cmd = {car.d2, car.d1, car.n, car.u1, car.u2};

    elevator_timer #(
        .Width (CntW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .dec_i      (tmr_dec),
        .count_o    (tmr_count),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        floor_d      = floor_q;
        dir_d        = dir_q;
        two_d        = two_q;
        err_d        = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = FloorLoad;
        tmr_dec      = 1'b0;
        case (state_q)
            StIdle: begin
                if (cmd != CMD_NOP) begin
                    if (legal_move(floor_q, cmd)) begin
                        state_d  = StMove;
                        dir_d    = cmd[CMD_U1] | cmd[CMD_U2];
                        two_d    = cmd[CMD_U2] | cmd[CMD_D2];
                        tmr_load = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StMove: begin
                if (tmr_zero) begin
                    floor_d  = dir_q ? floor_q + 2'd1 : floor_q - 2'd1;
                    tmr_load = 1'b1;
                    if (two_q) begin
                        two_d = 1'b0;
                    end else begin
                        state_d      = StDoor;
                        tmr_load_val = DoorLoad;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            StDoor: begin
                if (tmr_zero) state_d = StIdle;
                else          tmr_dec = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            floor_q <= F1;
            dir_q   <= 1'b1;
            two_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            floor_q <= floor_d;
            dir_q   <= dir_d;
            two_q   <= two_d;
            err_q   <= err_d;
        end
    end

    assign car.ready     = (state_q == StIdle);
    assign car.moving    = (state_q == StMove);
    assign car.door_open = (state_q == StDoor);
    // The counter only falls during the dwell, so the load value marks its first cycle.
    assign car.arrive    = (state_q == StDoor) && (tmr_count == DoorLoad);
    assign car.dir_up    = dir_q;
    assign car.cmd_err   = err_q;
    assign car.floor     = floor_q;
    assign car.at_f1     = (floor_q == F1);
    assign car.at_f2     = (floor_q == F2);
    assign car.at_f3     = (floor_q == F3);

endmodule

// File: tb/tb_elevator_car.sv
// Directed bench for elevator_car (FLOOR_TICKS=4, DOOR_TICKS=3).
// Status vector: {ready, moving, dir_up, door_open, arrive, cmd_err, floor, at_f3, at_f2, at_f1}.
module tb_elevator_car;
    import elevator_pkg::*;

    localparam logic [4:0] C_D2 = 5'b10000;
    localparam logic [4:0] C_D1 = 5'b01000;
    localparam logic [4:0] C_N  = 5'b00100;
    localparam logic [4:0] C_U1 = 5'b00010;
    localparam logic [4:0] C_U2 = 5'b00001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    elevator_car_if bus ();

    elevator_car #(
        .FLOOR_TICKS (4),
        .DOOR_TICKS  (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .car (bus)
    );

    task automatic set_cmd(input logic [4:0] c);
        {bus.d2, bus.d1, bus.n, bus.u1, bus.u2} = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] status();
        return {bus.ready, bus.moving, bus.dir_up, bus.door_open, bus.arrive, bus.cmd_err,
                bus.floor, bus.at_f3, bus.at_f2, bus.at_f1};
    endfunction

    function automatic logic [10:0] expv(input logic rdy, input logic mov, input logic dir,
                                         input logic door, input logic arr, input logic err,
                                         input logic [1:0] fl);
        logic [2:0] at;
        at = 3'b001 << (fl - 2'd1);
        return {rdy, mov, dir, door, arr, err, fl, at};
    endfunction

    task automatic test_reset();
        logic [10:0] e;
        rst = 1'b1;
        set_cmd(5'($urandom));
        step();
        set_cmd(5'($urandom));
        step();
        rst = 1'b0;
        set_cmd(C_N);
        e = expv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        checks++;
        if (status() !== e) begin
            failures++;
            $display("FAIL reset_state: got %b want %b", status(), e);
        end
        step();
        checks++;
        if (status() !== e) begin
            failures++;
            $display("FAIL reset_hold_n: got %b want %b", status(), e);
        end
    endtask

    task automatic test_illegal();
        logic [4:0]  vecs [3];
        logic [10:0] e_err, e_ok;
        vecs[0] = C_D1;
        vecs[1] = C_U1 | C_D1;
        vecs[2] = 5'b00000;
        e_err = expv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
        e_ok  = expv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        for (int i = 0; i < 3; i++) begin
            set_cmd(vecs[i]);
            step();
            set_cmd(C_N);
            checks++;
            if (status() !== e_err) begin
                failures++;
                $display("FAIL illegal_%0d_err: got %b want %b", i, status(), e_err);
            end
            step();
            checks++;
            if (status() !== e_ok) begin
                failures++;
                $display("FAIL illegal_%0d_pulse_end: got %b want %b", i, status(), e_ok);
            end
        end
    endtask

    task automatic test_two_floor();
        logic [10:0] e;
        logic [1:0]  fl;
        set_cmd(C_U2);
        step();
        set_cmd(C_N);
        e = expv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        checks++;
        if (status() !== e) begin
            failures++;
            $display("FAIL u2_edge0: got %b want %b", status(), e);
        end
        for (int k = 1; k <= 11; k++) begin
            step();
            fl = (k < 4) ? 2'd1 : ((k < 8) ? 2'd2 : 2'd3);
            e = expv(k == 11, k <= 7, 1'b1, (k >= 8) && (k <= 10), k == 8, 1'b0, fl);
            checks++;
            if (status() !== e) begin
                failures++;
                $display("FAIL u2_edge%0d: got %b want %b", k, status(), e);
            end
        end
    endtask

    task automatic test_n_and_down();
        logic [10:0] e;
        // F3 -> F2 first
        set_cmd(C_D1);
        step();
        set_cmd(C_N);
        repeat (4) step();
        e = expv(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2);
        checks++;
        if (status() !== e) begin
            failures++;
            $display("FAIL d1_f3_arrive: got %b want %b", status(), e);
        end
        repeat (3) step();
        e = expv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (status() !== e) begin
                failures++;
                $display("FAIL n_at_f2_%0d: got %b want %b", k, status(), e);
            end
        end
        set_cmd(C_D1);
        step();
        set_cmd(C_N);
        e = expv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
        checks++;
        if (status() !== e) begin
            failures++;
            $display("FAIL d1_f2_edge0: got %b want %b", status(), e);
        end
        repeat (3) step();
        checks++;
        if (status() !== e) begin
            failures++;
            $display("FAIL d1_f2_edge3: got %b want %b", status(), e);
        end
        step();
        e = expv(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        checks++;
        if (status() !== e) begin
            failures++;
            $display("FAIL d1_f2_edge4: got %b want %b", status(), e);
        end
        repeat (3) step();
        e = expv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        checks++;
        if (status() !== e) begin
            failures++;
            $display("FAIL d1_f2_ready: got %b want %b", status(), e);
        end
    endtask

    task automatic test_busy_ignore();
        logic [10:0] e;
        logic [1:0]  fl;
        set_cmd(C_U1);
        step();
        set_cmd(C_U2);
        e = expv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        checks++;
        if (status() !== e) begin
            failures++;
            $display("FAIL busy_edge0: got %b want %b", status(), e);
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            fl = (k < 4) ? 2'd1 : 2'd2;
            e = expv(k >= 7, k <= 3, 1'b1, (k >= 4) && (k <= 6), k == 4, k == 8, fl);
            checks++;
            if (status() !== e) begin
                failures++;
                $display("FAIL busy_edge%0d: got %b want %b", k, status(), e);
            end
        end
        set_cmd(C_N);
        step();
        e = expv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
        checks++;
        if (status() !== e) begin
            failures++;
            $display("FAIL busy_after: got %b want %b", status(), e);
        end
    endtask

    task automatic test_reset_mid_move();
        logic [10:0] e_rst, e;
        e_rst = expv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (status() !== e_rst) begin
            failures++;
            $display("FAIL rst_from_f2: got %b want %b", status(), e_rst);
        end
        set_cmd(C_U2);
        step();
        set_cmd(C_N);
        repeat (5) step();
        e = expv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
        checks++;
        if (status() !== e) begin
            failures++;
            $display("FAIL rst_mid_pre: got %b want %b", status(), e);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (status() !== e_rst) begin
            failures++;
            $display("FAIL rst_mid_snap: got %b want %b", status(), e_rst);
        end
        step();
        checks++;
        if (status() !== e_rst) begin
            failures++;
            $display("FAIL rst_mid_no_arrive: got %b want %b", status(), e_rst);
        end
    endtask

    task automatic test_closed_loop();
        int         cur, tgt, delta;
        logic [4:0] c;
        logic       done;
        cur = 1;
        for (int r = 0; r < 25; r++) begin
            tgt   = int'($urandom_range(3, 1));
            delta = tgt - cur;
            case (delta)
                2:       c = C_U2;
                1:       c = C_U1;
                -1:      c = C_D1;
                -2:      c = C_D2;
                default: c = C_N;
            endcase
            set_cmd(c);
            step();
            set_cmd(C_N);
            done = 1'b0;
            for (int k = 0; k < 20 && !done; k++) begin
                checks++;
                if (({bus.at_f3, bus.at_f2, bus.at_f1} !== (3'b001 << (bus.floor - 2'd1)))
                    || (bus.moving && bus.door_open) || (bus.cmd_err !== 1'b0)) begin
                    failures++;
                    $display("FAIL loop_invariant req%0d: at=%b floor=%0d mov=%b door=%b err=%b",
                             r, {bus.at_f3, bus.at_f2, bus.at_f1}, bus.floor, bus.moving,
                             bus.door_open, bus.cmd_err);
                end
                if (bus.ready === 1'b1) done = 1'b1;
                else                    step();
            end
            checks++;
            if (!done || (int'(bus.floor) != tgt)) begin
                failures++;
                $display("FAIL loop_arrival req%0d: ready=%b floor=%0d want floor=%0d",
                         r, bus.ready, bus.floor, tgt);
            end
            cur = tgt;
        end
    endtask

    initial begin
        set_cmd(C_N);
        test_reset();
        test_illegal();
        test_two_floor();
        test_n_and_down();
        test_busy_ignore();
        test_reset_mid_move();
        test_closed_loop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
